adc_snapshot_ctrl: RTL

ADC_SNAPSHOT_CTRL -- requirements
Module: adc_snapshot_ctrl

---
 rtl/adc_snap_pkg.sv | 18 +
 rtl/adc_snapshot_ctrl_if.sv | 12 +
 rtl/snap_trig_detect.sv | 24 ++
 rtl/adc_snapshot_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/adc_snap_pkg.sv
// Shared types for the ADC snapshot controller: FSM state and trigger mode encodings.
package adc_snap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_DONE      = 2'd3
    } snap_state_t;

    typedef enum logic [1:0] {
        TRIG_IMMEDIATE = 2'd0,
        TRIG_EXTERNAL  = 2'd1,
        TRIG_THRESHOLD = 2'd2,
        TRIG_RESERVED  = 2'd3
    } trig_mode_t;

endpackage

// File: rtl/adc_snapshot_ctrl_if.sv
// BRAM write port driven by the snapshot controller (master) into the capture memory (slave).
interface adc_snapshot_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_din;
    logic                  bram_we;

    modport master (output bram_addr, output bram_din, output bram_we);
    modport slave  (input  bram_addr, input  bram_din, input  bram_we);
endinterface

// File: rtl/snap_trig_detect.sv
// Per-beat threshold detector: hit when any signed sample in the beat is >= threshold.
module snap_trig_detect #(
    parameter int N_SAMPLES    = 8,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic [N_SAMPLES*SAMPLE_WIDTH-1:0] beat,
    input  logic [SAMPLE_WIDTH-1:0]           threshold,
    output logic                              hit
);

    logic signed [SAMPLE_WIDTH-1:0] sample;

    always_comb begin
        hit    = 1'b0;
        sample = '0;
        for (int i = 0; i < N_SAMPLES; i++) begin
            sample = beat[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            if (sample >= $signed(threshold)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_snapshot_ctrl.sv
// Arm/trigger/capture controller writing one selected ADC stream into a BRAM.
//   state        | meaning
//   ST_IDLE      | no capture pending
//   ST_WAIT_TRIG | armed, waiting for trigger on a valid beat of the selected channel
//   ST_CAPTURE   | writing every valid beat of the selected channel
//   ST_DONE      | capture finished (length reached or stall watchdog), holds until arm
module adc_snapshot_ctrl
    import adc_snap_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int N_SAMPLES    = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                                  fpga_clk,
    input  logic                                  arst_n,
    input  logic [N_CH*N_SAMPLES*SAMPLE_WIDTH-1:0] s_axis_tdata,
    input  logic [N_CH-1:0]                       s_axis_tvalid,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
    input  logic [1:0]                            trig_mode,
    input  logic [SAMPLE_WIDTH-1:0]               threshold,
    input  logic [ADDR_WIDTH-1:0]                 capture_len,
    input  logic                                  arm,
    input  logic                                  abort,
    input  logic                                  ext_trig,
    adc_snapshot_ctrl_if.master                   bram,
    output logic                                  busy,
    output logic                                  done,
    output logic [ADDR_WIDTH:0]                   words_written,
    output logic                                  overflow_err
);

    localparam int BEAT_W = N_SAMPLES * SAMPLE_WIDTH;
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [ADDR_WIDTH:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    snap_state_t           state, state_nxt;
    logic [CH_W-1:0]       cfg_ch;
    trig_mode_t            cfg_mode;
    logic [SAMPLE_WIDTH-1:0] cfg_thr;
    logic [ADDR_WIDTH-1:0] cfg_len;
    logic [ADDR_WIDTH-1:0] wd_cnt;

    logic [BEAT_W-1:0]     ch_beat [N_CH];
    logic [BEAT_W-1:0]     sel_beat;
    logic                  sel_valid;
    logic                  thr_hit;
    logic                  fire;
    logic                  accept;
    logic                  load_cfg;
    logic                  wd_expire;
    logic [ADDR_WIDTH:0]   len_full;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign ch_beat[k] = s_axis_tdata[k*BEAT_W +: BEAT_W];
    end

    // Explicit compare-mux keeps an out-of-range ch_sel from ever selecting anything.
    always_comb begin
        sel_valid = 1'b0;
        sel_beat  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cfg_ch == CH_W'(k)) begin
                sel_valid = s_axis_tvalid[k];
                sel_beat  = ch_beat[k];
            end
        end
    end

    snap_trig_detect #(
        .N_SAMPLES    (N_SAMPLES),
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_trig_detect (
        .beat      (sel_beat),
        .threshold (cfg_thr),
        .hit       (thr_hit)
    );

    assign len_full = (cfg_len == '0) ? FULL_LEN : {1'b0, cfg_len};

    always_comb begin
        fire = 1'b0;
        case (cfg_mode)
            TRIG_EXTERNAL:  fire = sel_valid && ext_trig;
            TRIG_THRESHOLD: fire = sel_valid && thr_hit;
            default:        fire = sel_valid;
        endcase
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load_cfg  = 1'b0;
        wd_expire = 1'b0;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_nxt = ST_WAIT_TRIG;
                        load_cfg  = 1'b1;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (fire) begin
                        accept    = 1'b1;
                        state_nxt = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // Final word is already on the write port; stop before accepting more.
                    if (words_written == len_full) begin
                        state_nxt = ST_DONE;
                    end else if (sel_valid) begin
                        accept = 1'b1;
                    end else if (wd_cnt == '0) begin
                        wd_expire = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge fpga_clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge fpga_clk or negedge arst_n) begin
        if (!arst_n) begin
            bram.bram_we   <= 1'b0;
            bram.bram_addr <= '0;
            bram.bram_din  <= '0;
            words_written  <= '0;
            overflow_err   <= 1'b0;
            cfg_ch         <= '0;
            cfg_mode       <= TRIG_IMMEDIATE;
            cfg_thr        <= '0;
            cfg_len        <= '0;
            wd_cnt         <= '1;
        end else begin
            bram.bram_we <= accept;
            if (accept) begin
                bram.bram_addr <= words_written[ADDR_WIDTH-1:0];
                bram.bram_din  <= sel_beat;
                words_written  <= words_written + 1'b1;
            end
            if (load_cfg) begin
                cfg_ch        <= ch_sel;
                cfg_mode      <= trig_mode_t'(trig_mode);
                cfg_thr       <= threshold;
                cfg_len       <= capture_len;
                words_written <= '0;
                overflow_err  <= 1'b0;
            end
            if (wd_expire) begin
                overflow_err <= 1'b1;
            end
            // Stall watchdog: reloads on every accepted beat, counts down idle capture cycles.
            if (accept || state != ST_CAPTURE) begin
                wd_cnt <= '1;
            end else begin
                wd_cnt <= wd_cnt - 1'b1;
            end
        end
    end

    assign busy = (state == ST_WAIT_TRIG) || (state == ST_CAPTURE);
    assign done = (state == ST_DONE);

endmodule
